song_sequencer: RTL and testbench



---
 rtl/piano_pkg.sv | 25 ++
 rtl/song_rom.sv | 76 +++++++
 rtl/song_sequencer.sv | 149 ++++++++++++++
 tb/tb_song_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// Shared constants for the piano auto-play path: sequencer state codes,
// note/duration widths and the song ROM word layout.
package piano_pkg;

    localparam int unsigned NOTE_W = 5;
    localparam int unsigned DUR_W  = 3;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned SONG_W = 2;

    localparam logic [NOTE_W-1:0] NOTE_REST = 5'd0;
    localparam logic [NOTE_W-1:0] NOTE_END  = 5'd31;

    // Externally visible sequencer state, shared with the display stage.
    localparam logic [1:0] SEQ_STOP  = 2'b00;
    localparam logic [1:0] SEQ_PLAY  = 2'b01;
    localparam logic [1:0] SEQ_PAUSE = 2'b10;

    function automatic logic [NOTE_W+DUR_W-1:0] rom_word(
        input logic [NOTE_W-1:0] note,
        input logic [DUR_W-1:0]  dur
    );
        return {note, dur};
    endfunction

endpackage

// File: rtl/song_rom.sv
// Combinational 256x8 song table addressed by {song, idx}; each word is
// {note, dur}. Unlisted entries read as the end marker.
module song_rom
    import piano_pkg::*;
(
    input  logic [SONG_W+IDX_W-1:0] addr_i,
    output logic [NOTE_W-1:0]       note_o,
    output logic [DUR_W-1:0]        dur_o
);

    logic [NOTE_W+DUR_W-1:0] word;

    always_comb begin
        word = rom_word(NOTE_END, 3'd0);
        case (addr_i)
            // Song 0: Twinkle Twinkle
            8'h00: word = rom_word(5'd8,  3'd0);
            8'h01: word = rom_word(5'd8,  3'd0);
            8'h02: word = rom_word(5'd12, 3'd0);
            8'h03: word = rom_word(5'd12, 3'd0);
            8'h04: word = rom_word(5'd13, 3'd0);
            8'h05: word = rom_word(5'd13, 3'd0);
            8'h06: word = rom_word(5'd12, 3'd1);
            8'h07: word = rom_word(5'd11, 3'd0);
            8'h08: word = rom_word(5'd11, 3'd0);
            8'h09: word = rom_word(5'd10, 3'd0);
            8'h0A: word = rom_word(5'd10, 3'd0);
            8'h0B: word = rom_word(5'd9,  3'd0);
            8'h0C: word = rom_word(5'd9,  3'd0);
            8'h0D: word = rom_word(5'd8,  3'd1);
            // Song 1: Ode to Joy
            8'h40: word = rom_word(5'd10, 3'd0);
            8'h41: word = rom_word(5'd10, 3'd0);
            8'h42: word = rom_word(5'd11, 3'd0);
            8'h43: word = rom_word(5'd12, 3'd0);
            8'h44: word = rom_word(5'd12, 3'd0);
            8'h45: word = rom_word(5'd11, 3'd0);
            8'h46: word = rom_word(5'd10, 3'd0);
            8'h47: word = rom_word(5'd9,  3'd0);
            8'h48: word = rom_word(5'd8,  3'd0);
            8'h49: word = rom_word(5'd8,  3'd0);
            8'h4A: word = rom_word(5'd9,  3'd0);
            8'h4B: word = rom_word(5'd10, 3'd0);
            8'h4C: word = rom_word(5'd10, 3'd1);
            8'h4D: word = rom_word(5'd9,  3'd0);
            8'h4E: word = rom_word(5'd9,  3'd1);
            // Song 2: Mary Had a Little Lamb
            8'h80: word = rom_word(5'd10, 3'd0);
            8'h81: word = rom_word(5'd9,  3'd0);
            8'h82: word = rom_word(5'd8,  3'd0);
            8'h83: word = rom_word(5'd9,  3'd0);
            8'h84: word = rom_word(5'd10, 3'd0);
            8'h85: word = rom_word(5'd10, 3'd0);
            8'h86: word = rom_word(5'd10, 3'd1);
            8'h87: word = rom_word(5'd9,  3'd0);
            8'h88: word = rom_word(5'd9,  3'd0);
            8'h89: word = rom_word(5'd9,  3'd1);
            8'h8A: word = rom_word(5'd10, 3'd0);
            8'h8B: word = rom_word(5'd12, 3'd0);
            8'h8C: word = rom_word(5'd12, 3'd1);
            // Song 3: test scale
            8'hC0: word = rom_word(5'd1,  3'd0);
            8'hC1: word = rom_word(5'd2,  3'd0);
            8'hC2: word = rom_word(5'd3,  3'd0);
            8'hC3: word = rom_word(5'd4,  3'd0);
            8'hC4: word = rom_word(5'd5,  3'd0);
            8'hC5: word = rom_word(5'd6,  3'd0);
            8'hC6: word = rom_word(5'd7,  3'd0);
            default: word = rom_word(NOTE_END, 3'd0);
        endcase
    end

    assign note_o = word[NOTE_W+DUR_W-1:DUR_W];
    assign dur_o  = word[DUR_W-1:0];

endmodule

// File: rtl/song_sequencer.sv
// Duration-aware song sequencer: steps through a stored song, emitting note
// codes with per-note length and a trailing articulation gap.
module song_sequencer
    import piano_pkg::*;
#(
    parameter int unsigned TICKS_PER_BEAT = 25_000_000,
    parameter int unsigned GAP_TICKS      = 2_500_000,
    parameter bit          LOOP           = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SONG_W-1:0] song_sel,
    input  logic              cmd_play,
    input  logic              cmd_pause,
    input  logic              cmd_stop,
    output logic [NOTE_W-1:0] note,
    output logic              note_valid,
    output logic [IDX_W-1:0]  note_idx,
    output logic [1:0]        seq_state,
    output logic              song_done
);

    localparam int unsigned TW = $clog2(TICKS_PER_BEAT);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_BEAT - 1);
    localparam logic [TW-1:0] GAP_T    = TW'(GAP_TICKS);

    // FETCH takes the one code the external encoding leaves free.
    localparam logic [1:0] ST_STOP  = SEQ_STOP;
    localparam logic [1:0] ST_PLAY  = SEQ_PLAY;
    localparam logic [1:0] ST_PAUSE = SEQ_PAUSE;
    localparam logic [1:0] ST_FETCH = 2'b11;

    logic [1:0]        state_q, state_d;
    logic [SONG_W-1:0] song_q,  song_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [NOTE_W-1:0] note_q,  note_d;
    logic [DUR_W-1:0]  beat_q,  beat_d;
    logic [TW-1:0]     tick_q,  tick_d;
    logic              done_q,  done_d;

    logic [NOTE_W-1:0] rom_note;
    logic [DUR_W-1:0]  rom_dur;
    logic              note_last;

    song_rom u_song_rom (
        .addr_i ({song_q, idx_q}),
        .note_o (rom_note),
        .dur_o  (rom_dur)
    );

    assign note_last = (tick_q == '0) && (beat_q == '0);

    always_comb begin
        state_d = state_q;
        song_d  = song_q;
        idx_d   = idx_q;
        note_d  = note_q;
        beat_d  = beat_q;
        tick_d  = tick_q;
        done_d  = 1'b0;

        case (state_q)
            ST_STOP: begin
                if (cmd_play && !cmd_pause && !cmd_stop) begin
                    song_d  = song_sel;
                    idx_d   = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (cmd_stop) begin
                    state_d = ST_STOP;
                end else if (rom_note == NOTE_END) begin
                    done_d  = 1'b1;
                    idx_d   = '0;
                    state_d = LOOP ? ST_FETCH : ST_STOP;
                end else begin
                    note_d  = rom_note;
                    beat_d  = rom_dur;
                    tick_d  = TICK_MAX;
                    state_d = cmd_pause ? ST_PAUSE : ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (cmd_stop) begin
                    state_d = ST_STOP;
                end else if (!cmd_pause && note_last) begin
                    idx_d   = idx_q + 6'd1;
                    state_d = ST_FETCH;
                end else begin
                    // A pause still consumes the tick of the cycle it arrives in;
                    // a pause on the final tick holds there and advances on resume.
                    if (cmd_pause) begin
                        state_d = ST_PAUSE;
                    end
                    if (tick_q != '0) begin
                        tick_d = tick_q - 1'b1;
                    end else if (beat_q != '0) begin
                        beat_d = beat_q - 1'b1;
                        tick_d = TICK_MAX;
                    end
                end
            end
            ST_PAUSE: begin
                if (cmd_stop) begin
                    state_d = ST_STOP;
                end else if (cmd_play || cmd_pause) begin
                    state_d = ST_PLAY;
                end
            end
            default: state_d = ST_STOP;
        endcase

        if (state_d == ST_STOP) begin
            idx_d  = '0;
            note_d = NOTE_REST;
            beat_d = '0;
            tick_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_STOP;
            song_q  <= '0;
            idx_q   <= '0;
            note_q  <= NOTE_REST;
            beat_q  <= '0;
            tick_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            song_q  <= song_d;
            idx_q   <= idx_d;
            note_q  <= note_d;
            beat_q  <= beat_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    assign note = ((state_q == ST_PLAY) && !((beat_q == '0) && (tick_q < GAP_T)))
                  ? note_q : NOTE_REST;
    assign note_valid = (state_q != ST_STOP);
    assign note_idx   = idx_q;
    assign seq_state  = (state_q == ST_FETCH) ? SEQ_PLAY : state_q;
    assign song_done  = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with short beats (4 ticks, 1-tick gap);
// a second instance with looping enabled shares the stimulus.
module tb_song_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] song_sel;
    logic       cmd_play, cmd_pause, cmd_stop;

    logic [4:0] note,   l_note;
    logic       note_valid, l_note_valid;
    logic [5:0] note_idx, l_note_idx;
    logic [1:0] seq_state, l_seq_state;
    logic       song_done, l_song_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    song_sequencer #(
        .TICKS_PER_BEAT (4),
        .GAP_TICKS      (1),
        .LOOP           (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .song_sel   (song_sel),
        .cmd_play   (cmd_play),
        .cmd_pause  (cmd_pause),
        .cmd_stop   (cmd_stop),
        .note       (note),
        .note_valid (note_valid),
        .note_idx   (note_idx),
        .seq_state  (seq_state),
        .song_done  (song_done)
    );

    song_sequencer #(
        .TICKS_PER_BEAT (4),
        .GAP_TICKS      (1),
        .LOOP           (1'b1)
    ) dut_loop (
        .clk        (clk),
        .rst        (rst),
        .song_sel   (song_sel),
        .cmd_play   (cmd_play),
        .cmd_pause  (cmd_pause),
        .cmd_stop   (cmd_stop),
        .note       (l_note),
        .note_valid (l_note_valid),
        .note_idx   (l_note_idx),
        .seq_state  (l_seq_state),
        .song_done  (l_song_done)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_play();
        cmd_play = 1'b1;
        step(1);
        cmd_play = 1'b0;
    endtask

    initial begin
        rst = 1'b1; song_sel = 2'd0;
        cmd_play = 1'b0; cmd_pause = 1'b0; cmd_stop = 1'b0;
        step(2);
        rst = 1'b0;
        check("rst_note",  int'(note), 0);
        check("rst_valid", int'(note_valid), 0);
        check("rst_idx",   int'(note_idx), 0);
        check("rst_state", int'(seq_state), 0);
        check("rst_done",  int'(song_done), 0);

        // Song 3 start to finish, no loop
        song_sel = 2'd3;
        pulse_play();
        check("fetch0_state", int'(seq_state), 1);
        check("fetch0_valid", int'(note_valid), 1);
        check("fetch0_note",  int'(note), 0);
        for (int k = 1; k <= 7; k++) begin
            for (int c = 0; c < 4; c++) begin
                step(1);
                check("s3_note", int'(note), (c < 3) ? k : 0);
            end
            check("s3_play_idx", int'(note_idx), k - 1);
            step(1);
            check("s3_fetch_note", int'(note), 0);
            check("s3_fetch_idx", int'(note_idx), k);
        end
        check("end_done_pre", int'(song_done), 0);
        step(1);
        check("end_done",  int'(song_done), 1);
        check("end_state", int'(seq_state), 0);
        check("end_idx",   int'(note_idx), 0);
        check("end_note",  int'(note), 0);
        step(1);
        check("end_done_clr", int'(song_done), 0);

        // Pause in the 2nd cycle of note 3, hold, resume
        pulse_play();
        step(10);
        check("p_fetch_idx", int'(note_idx), 2);
        step(1);
        check("p_n3_c1", int'(note), 3);
        step(1);
        cmd_pause = 1'b1;
        step(1);
        cmd_pause = 1'b0;
        check("p_state", int'(seq_state), 2);
        check("p_note",  int'(note), 0);
        check("p_valid", int'(note_valid), 1);
        check("p_idx",   int'(note_idx), 2);
        step(7);
        check("p_hold_state", int'(seq_state), 2);
        check("p_hold_note",  int'(note), 0);
        pulse_play();
        check("r_note",  int'(note), 3);
        check("r_state", int'(seq_state), 1);
        step(1);
        check("r_gap",   int'(note), 0);
        check("r_gap_idx", int'(note_idx), 2);
        step(1);
        check("r_fetch_idx", int'(note_idx), 3);
        check("r_fetch_note", int'(note), 0);
        step(1);
        check("r_n4", int'(note), 4);

        // Stop and pause together -> STOP
        cmd_stop = 1'b1; cmd_pause = 1'b1;
        step(1);
        cmd_stop = 1'b0; cmd_pause = 1'b0;
        check("sp_state", int'(seq_state), 0);
        check("sp_note",  int'(note), 0);
        check("sp_idx",   int'(note_idx), 0);
        check("sp_valid", int'(note_valid), 0);

        // Song 0 from idx 0; song_sel change mid-play ignored
        song_sel = 2'd0;
        pulse_play();
        check("s0_fetch_idx", int'(note_idx), 0);
        step(1);
        check("s0_n0", int'(note), 8);
        song_sel = 2'd2;
        step(4);
        check("s0_fetch1_idx", int'(note_idx), 1);
        step(1);
        check("s0_n1", int'(note), 8);

        // Stop, then pause in STOP is ignored
        cmd_stop = 1'b1;
        step(1);
        cmd_stop = 1'b0;
        check("stop_state", int'(seq_state), 0);
        cmd_pause = 1'b1;
        step(1);
        cmd_pause = 1'b0;
        check("stop_pause_state", int'(seq_state), 0);
        check("stop_pause_valid", int'(note_valid), 0);

        // Reset mid-note
        song_sel = 2'd3;
        pulse_play();
        step(2);
        check("mr_note_pre", int'(note), 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("mr_note",  int'(note), 0);
        check("mr_valid", int'(note_valid), 0);
        check("mr_idx",   int'(note_idx), 0);
        check("mr_state", int'(seq_state), 0);
        check("mr_done",  int'(song_done), 0);
        check("mr_l_state", int'(l_seq_state), 0);
        step(3);
        check("mr_stay_state", int'(seq_state), 0);
        check("mr_stay_note",  int'(note), 0);

        // Looping instance on song 3
        pulse_play();
        step(35);
        check("lp_end_idx",  int'(l_note_idx), 7);
        check("lp_done_pre", int'(l_song_done), 0);
        step(1);
        check("lp_done",   int'(l_song_done), 1);
        check("lp_state",  int'(l_seq_state), 1);
        check("lp_idx",    int'(l_note_idx), 0);
        check("lp_note",   int'(l_note), 0);
        check("nl_done",   int'(song_done), 1);
        check("nl_state",  int'(seq_state), 0);
        step(1);
        check("lp_n1",       int'(l_note), 1);
        check("lp_done_clr", int'(l_song_done), 0);
        check("lp_n1_state", int'(l_seq_state), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
